// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the register command sequencer.
package reg_seq_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_SHR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_ROT  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Number of strobe cycles a command expands to.
  // CLR/LOAD are always one cycle; NOP is none.
  function automatic logic [DATA_W-1:0] rep_count(input op_e op, input logic [DATA_W-1:0] arg);
    logic [DATA_W-1:0] n;
    case (op)
      OP_NOP:          n = '0;
      OP_CLR, OP_LOAD: n = DATA_W'(1);
      default:         n = arg;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_rep_cnt.sv
// Loadable repeat down-counter; stops at zero and flags a count of one.
module seq_rep_cnt
  import reg_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              dec,
  output logic              is_one
);

  logic [DATA_W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - DATA_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign is_one = (cnt_q == DATA_W'(1));

endmodule

// File: rtl/reg_op_sequencer.sv
// Expands one command into a stream of one-hot register control strobes.
//   state  | meaning
//   S_IDLE | waiting for a command, cmd_ready high
//   S_RUN  | one strobe per cycle until the repeat count is exhausted
//   S_DONE | one-cycle done pulse, then back to idle
module reg_op_sequencer
  import reg_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_arg,
  input  logic              cmd_fill,
  input  logic              abort,
  input  logic [DATA_W-1:0] reg_q,
  output logic              cl,
  output logic              ld,
  output logic              inc,
  output logic              dec,
  output logic              sr,
  output logic              sl,
  output logic              ir,
  output logic              il,
  output logic [DATA_W-1:0] in,
  output logic              done,
  output logic              busy
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] arg_q, arg_d;
  logic              fill_q, fill_d;

  logic              cnt_load;
  logic [DATA_W-1:0] cnt_load_val;
  logic              cnt_dec;
  logic              cnt_is_one;

  // Only the end bits of the register are rotate feedback.
  logic              unused_reg_mid;
  assign unused_reg_mid = ^reg_q[2:1];

  seq_rep_cnt u_rep_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .is_one   (cnt_is_one)
  );

  // Next-state, command latching and strobe decode.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg_d        = arg_q;
    fill_d       = fill_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    cl           = 1'b0;
    ld           = 1'b0;
    inc          = 1'b0;
    dec          = 1'b0;
    sr           = 1'b0;
    sl           = 1'b0;
    ir           = 1'b0;
    il           = 1'b0;
    in           = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d         = op_e'(cmd_op);
          arg_d        = cmd_arg;
          fill_d       = cmd_fill;
          cnt_load     = 1'b1;
          cnt_load_val = rep_count(op_e'(cmd_op), cmd_arg);
          state_d      = (cnt_load_val != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_is_one) state_d = S_DONE;
          case (op_q)
            OP_CLR:  cl = 1'b1;
            OP_LOAD: begin
              ld = 1'b1;
              in = arg_q;
            end
            OP_ADD:  inc = 1'b1;
            OP_SUB:  dec = 1'b1;
            OP_SHR: begin
              sr = 1'b1;
              ir = fill_q;
            end
            OP_SHL: begin
              sl = 1'b1;
              il = fill_q;
            end
            OP_ROT: begin
              if (fill_q) begin
                sl = 1'b1;
                il = reg_q[DATA_W-1];
              end else begin
                sr = 1'b1;
                ir = reg_q[0];
              end
            end
            default: ;
          endcase
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched command fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      arg_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      fill_q  <= fill_d;
    end
  end

endmodule
